// File: rtl/cpu_clk_pkg.sv
// Shared types and constants for the KLP32 clock/reset front end.
// cnt_w gives a counter width that stays at least one bit for tiny parameters.
package cpu_clk_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RUN_LO,
        RUN_HI,
        STEP_IDLE,
        STEP_HI
    } cc_state_t;

    localparam int STEP_COUNT_W = 16;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// Two-flop synchroniser plus counter debounce for an active-low push button.
// press_o is a one-cycle pulse on each accepted released-to-pressed transition.
module btn_debounce
    import cpu_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Processor clock/reset front end: divided free-run clock or debounced single step,
// a stretched synchronous processor reset, and a count of cpu_clk rising edges.
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_HALF        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int RESET_HOLD      = 16
) (
    input  logic                    clk,
    input  logic                    reset_in,
    input  logic                    run_mode,
    input  logic                    step_btn_n,
    output logic                    cpu_clk,
    output logic                    cpu_reset,
    output logic [STEP_COUNT_W-1:0] step_count
);

    localparam int PW = cnt_w(DIV_HALF);
    localparam int HW = cnt_w(RESET_HOLD);
    localparam logic [PW-1:0] PH_MAX   = PW'(DIV_HALF - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD - 1);

    cc_state_t               state_q;
    logic [PW-1:0]           ph_q;
    logic [HW-1:0]           hold_q;
    logic                    run_s1_q;
    logic                    run_s2_q;
    logic                    cpu_clk_q;
    logic                    cpu_reset_q;
    logic [STEP_COUNT_W-1:0] step_count_q;
    logic [STEP_COUNT_W-1:0] step_count_d;
    logic                    press;
    logic                    ph_last;
    logic                    enter_hi;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk_i  (clk),
        .rst_ni (reset_in),
        .btn_n_i(step_btn_n),
        .press_o(press)
    );

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
        end else begin
            run_s1_q <= run_mode;
            run_s2_q <= run_s1_q;
        end
    end

    assign ph_last = (ph_q == PH_MAX);

    // Every entry into a high phase is one processor clock edge; mode beats a press.
    assign enter_hi = ((state_q == RUN_LO) && ph_last && run_s2_q) ||
                      ((state_q == STEP_IDLE) && !run_s2_q && press);

    always_comb begin
        step_count_d = step_count_q;
        if (enter_hi) begin
            step_count_d = step_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            step_count_q <= '0;
        end else begin
            step_count_q <= step_count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= HOLD;
            ph_q        <= '0;
            hold_q      <= '0;
            cpu_clk_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    cpu_clk_q <= 1'b0;
                    ph_q      <= '0;
                    if (hold_q == HOLD_MAX) begin
                        hold_q      <= '0;
                        cpu_reset_q <= 1'b0;
                        state_q     <= run_s2_q ? RUN_LO : STEP_IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RUN_LO: begin
                    if (ph_last) begin
                        ph_q <= '0;
                        if (run_s2_q) begin
                            state_q   <= RUN_HI;
                            cpu_clk_q <= 1'b1;
                        end else begin
                            state_q <= STEP_IDLE;
                        end
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                // Mode is not sampled while high so no runt pulse can reach the core.
                RUN_HI: begin
                    if (ph_last) begin
                        ph_q      <= '0;
                        state_q   <= RUN_LO;
                        cpu_clk_q <= 1'b0;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                STEP_IDLE: begin
                    ph_q <= '0;
                    if (run_s2_q) begin
                        state_q <= RUN_LO;
                    end else if (press) begin
                        state_q   <= STEP_HI;
                        cpu_clk_q <= 1'b1;
                    end
                end
                STEP_HI: begin
                    if (ph_last) begin
                        ph_q      <= '0;
                        state_q   <= STEP_IDLE;
                        cpu_clk_q <= 1'b0;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= HOLD;
                    ph_q        <= '0;
                    hold_q      <= '0;
                    cpu_clk_q   <= 1'b0;
                    cpu_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_clk    = cpu_clk_q;
    assign cpu_reset  = cpu_reset_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with DIV_HALF=4, DEBOUNCE_CYCLES=8, RESET_HOLD=4.
module tb_cpu_clock_ctrl;

    logic        clk;
    logic        reset_in;
    logic        run_mode;
    logic        step_btn_n;
    logic        cpu_clk;
    logic        cpu_reset;
    logic [15:0] step_count;

    int compared = 0;
    int mismatched = 0;

    cpu_clock_ctrl #(
        .DIV_HALF       (4),
        .DEBOUNCE_CYCLES(8),
        .RESET_HOLD     (4)
    ) dut (
        .clk       (clk),
        .reset_in  (reset_in),
        .run_mode  (run_mode),
        .step_btn_n(step_btn_n),
        .cpu_clk   (cpu_clk),
        .cpu_reset (cpu_reset),
        .step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_in   = 1'b1;
        run_mode   = 1'b1;
        step_btn_n = 1'b1;
        #2 reset_in = 1'b0;
        tick();
        tick();
        chk("reset_cpu_clk", 32'(cpu_clk), 32'd0);
        chk("reset_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reset_step_count", 32'(step_count), 32'd0);

        // Release with free-run selected: reset falls on the 4th edge.
        reset_in = 1'b1;
        tick();
        tick();
        tick();
        chk("hold_edge3", 32'(cpu_reset), 32'd1);
        tick();
        chk("hold_release", 32'(cpu_reset), 32'd0);
        chk("hold_release_clk", 32'(cpu_clk), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("free_run_clk", 32'(cpu_clk), 32'((i / 4) % 2));
        end
        chk("free_run_count", 32'(step_count), 32'd3);

        // Drop the mode just after a rise: high phase must still last 4 cycles.
        run_mode = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("mode_drop_clk", 32'(cpu_clk), 32'(i <= 3));
        end
        chk("mode_drop_count", 32'(step_count), 32'd3);

        run_mode = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("resume_low", 32'(cpu_clk), 32'd0);
        end
        tick();
        chk("resume_rise", 32'(cpu_clk), 32'd1);
        chk("resume_count", 32'(step_count), 32'd4);
        run_mode = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("back_to_step_clk", 32'(cpu_clk), 32'(i <= 3));
        end

        // Single step: held press gives one 4-cycle pulse rising 12 cycles later.
        step_btn_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("step1_clk", 32'(cpu_clk), 32'((k >= 12) && (k <= 15)));
        end
        chk("step1_count", 32'(step_count), 32'd5);
        step_btn_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("release1_clk", 32'(cpu_clk), 32'd0);
        end
        step_btn_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("step2_clk", 32'(cpu_clk), 32'((k >= 12) && (k <= 15)));
        end
        chk("step2_count", 32'(step_count), 32'd6);
        step_btn_n = 1'b1;
        for (int k = 1; k <= 30; k++) tick();

        // 5-cycle glitches are shorter than the debounce window.
        for (int k = 0; k < 100; k++) begin
            step_btn_n = ((k / 5) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            chk("bounce_clk", 32'(cpu_clk), 32'd0);
        end
        step_btn_n = 1'b1;
        for (int k = 1; k <= 15; k++) tick();
        chk("bounce_count", 32'(step_count), 32'd6);

        // Asynchronous reset two cycles into a step pulse.
        step_btn_n = 1'b0;
        for (int k = 1; k <= 13; k++) tick();
        chk("pulse_before_reset", 32'(cpu_clk), 32'd1);
        chk("count_before_reset", 32'(step_count), 32'd7);
        #2 reset_in = 1'b0;
        #1;
        chk("async_cpu_clk", 32'(cpu_clk), 32'd0);
        chk("async_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("async_step_count", 32'(step_count), 32'd0);
        step_btn_n = 1'b1;
        tick();
        tick();
        reset_in = 1'b1;
        tick();
        tick();
        tick();
        chk("rehold_edge3", 32'(cpu_reset), 32'd1);
        tick();
        chk("rehold_release", 32'(cpu_reset), 32'd0);
        chk("rehold_clk", 32'(cpu_clk), 32'd0);
        chk("rehold_count", 32'(step_count), 32'd0);

        // Counter wrap from a preloaded value.
        tick();
        tick();
        tick();
        force dut.step_count_q = 16'hFFFE;
        tick();
        tick();
        release dut.step_count_q;
        tick();
        chk("wrap_preload", 32'(step_count), 32'h0000_FFFE);
        run_mode = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        chk("wrap_pre_rise", 32'(step_count), 32'h0000_FFFE);
        tick();
        chk("wrap_rise1_clk", 32'(cpu_clk), 32'd1);
        chk("wrap_ffff", 32'(step_count), 32'h0000_FFFF);
        for (int i = 1; i <= 8; i++) tick();
        chk("wrap_rise2_clk", 32'(cpu_clk), 32'd1);
        chk("wrap_zero", 32'(step_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Clock and reset front end for the KLP32 processor on the DE10-Lite. Derives the slow processor clock from the board oscillator, either free-running or single-stepped from a debounced push button. Also generates a synchronised processor reset and an edge counter for the display. Sits directly upstream of the processor instance in the top level; `cpu_clk` is the net that drives the processor `clk`, and `cpu_reset` is the net that drives the processor `reset`.

## Interface
Parameters:
- `DIV_HALF`, 25_000_000: `clk` cycles per half-period of `cpu_clk`, and the width of a step pulse; ≥1.
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable `clk` cycles before a button level is accepted; ≥1.
- `RESET_HOLD`, 16: `clk` cycles `cpu_reset` stays high after `reset_in` releases; ≥1.

Ports:
- `clk`  in  1  board clock; the only clock in the block.
- `reset_in`  in  1  reset. Asynchronous, active-low.
- `run_mode`  in  1  raw slide switch: 1 = free-run, 0 = single-step. Asynchronous.
- `step_btn_n`  in  1  raw push button, active-low (pressed = 0). Asynchronous and bouncy.
- `cpu_clk`  out  1  registered divided/stepped clock for the processor.
- `cpu_reset`  out  1  active-high processor reset.
- `step_count`  out  16  count of `cpu_clk` rising edges since reset; wraps.

## Operation
- **Input synchronisation:** `run_mode` and `step_btn_n` each pass through a 2-flop synchroniser.
- **Debounce:** the synchronised button is debounced.
  - A stable level register resets to 1 (released).
  - A counter increments while the synchronised value differs from the stable level, and clears whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level takes the new value and the counter clears.
  - `press` is a 1-cycle pulse on a stable 1→0 transition.
- **FSM states:** `HOLD`, `RUN_LO`, `RUN_HI`, `STEP_IDLE`, `STEP_HI`. A shared phase counter `ph` counts 0..`DIV_HALF`-1.
- **`HOLD`:** `cpu_reset`=1, `cpu_clk`=0. After `RESET_HOLD` cycles go to `RUN_LO` if synced `run_mode`=1, else `STEP_IDLE`. `cpu_reset` drops on the same edge.
- **`RUN_LO`:** `cpu_clk`=0. At `ph`=`DIV_HALF`-1:
  - if synced `run_mode`=1, go to `RUN_HI`;
  - else go to `STEP_IDLE`.
- **`RUN_HI`:** `cpu_clk`=1. At `ph`=`DIV_HALF`-1 go to `RUN_LO`. The mode is never sampled here, so a high phase always completes and no runt pulses occur.
- **`STEP_IDLE`:** `cpu_clk`=0, `ph` held at 0.
  - If synced `run_mode`=1, go to `RUN_LO`.
  - Else on `press`, go to `STEP_HI`.
  - If `press` and `run_mode`=1 arrive in the same cycle, mode wins and the press is dropped.
- **`STEP_HI`:** `cpu_clk`=1 for exactly `DIV_HALF` cycles, then go to `STEP_IDLE`. Presses during `STEP_HI` are ignored, not queued.
- **`step_count`:** increments by 1 on each transition into `RUN_HI` or `STEP_HI`. It wraps 0xFFFF→0x0000.
- **Reset mid-operation:** `reset_in`=0 at any time asynchronously forces:
  - state `HOLD`;
  - `cpu_clk`=0, `cpu_reset`=1, `step_count`=0;
  - all counters and synchronisers to reset values, with debounce stable level = 1.

## Timing
- **Reset values:** `cpu_clk`=0, `cpu_reset`=1, `step_count`=0.
- **Registered outputs:** all outputs come straight from flops, with no combinational path from inputs.
- **`cpu_reset` release:** deasserts synchronously exactly `RESET_HOLD` `clk` edges after the first `clk` edge that sees `reset_in`=1.
- **Free-run clock:** first `cpu_clk` rise is `DIV_HALF` cycles after `cpu_reset` falls. Period is 2·`DIV_HALF`, duty cycle 50%.
- **Step latency:** press-to-`cpu_clk` rise is 2 (sync) + `DEBOUNCE_CYCLES` + 1 (`press`) + 1 (state register) cycles.
- **Mode change latency:** 2 sync cycles, plus completion of the current half-period in run mode.

## Structure
- **Package `cpu_clk_pkg`:** holds the `cc_state_t` enum (`HOLD`, `RUN_LO`, `RUN_HI`, `STEP_IDLE`, `STEP_HI`) and the `STEP_COUNT_W` = 16 constant.
- **Sub-module `btn_debounce`:** contains the synchroniser, debounce counter, stable level and `press` pulse. It is parameterised by `DEBOUNCE_CYCLES` and is reusable for later buttons.
- **Counter widths:** derived with `$clog2` of the respective parameter.

## Test plan
Bench parameters: `DIV_HALF`=4, `DEBOUNCE_CYCLES`=8, `RESET_HOLD`=4.

1. **Reset release, free-run:** `run_mode`=1, release `reset_in` → `cpu_reset` falls on the 4th edge. First `cpu_clk` rise is 4 cycles later, then high 4 / low 4. After 3 rises `step_count`=3.
2. **Single step:** `run_mode`=0, hold `step_btn_n`=0 for 30 cycles → exactly one `cpu_clk` high pulse of 4 cycles, rising 12 cycles after the press. `step_count` goes 0→1. Release and press again → second pulse, `step_count`=2.
3. **Bounce rejection:** toggle `step_btn_n` with 5-cycle glitches for 100 cycles → no `cpu_clk` pulse and `step_count` unchanged. A second press during `STEP_HI` → still only one pulse.
4. **Mode switch during high:** drop `run_mode` while `cpu_clk`=1 in run mode → the high phase lasts the full 4 cycles, then `cpu_clk` stays 0 in `STEP_IDLE`. Raise `run_mode` → free-run resumes after sync + 4 cycles.
5. **Async reset mid-pulse:** pull `reset_in`=0 two cycles into a `STEP_HI` pulse → `cpu_clk`=0, `cpu_reset`=1, `step_count`=0 before the next `clk` edge. On release the normal 4-cycle hold follows.
6. **Counter wrap:** force `step_count` to 0xFFFE, free-run for 2 rises → 0xFFFF then 0x0000.
